// File: rtl/wb_stage_reg.sv
// Write-back stage register: picks ALU, formatted load or link data for the register bank,
// with a sticky HALT state and a saturating retired-instruction counter.
module wb_stage_reg #(
  parameter int NB_DATA     = 32,
  parameter int NB_REG      = 5,
  parameter int NB_PC       = 32,
  parameter int NB_CNT      = 32,
  parameter int LINK_OFFSET = 0
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_valid,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_reg_write,
  input  logic               i_mem_to_reg,
  input  logic [NB_DATA-1:0] i_mem_data,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic [NB_REG-1:0]  i_selected_reg,
  input  logic               i_r31_ctrl,
  input  logic [NB_PC-1:0]   i_pc,
  input  logic               i_hlt,
  input  logic [1:0]         i_load_size,
  input  logic               i_load_unsigned,
  input  logic [1:0]         i_byte_off,
  output logic               o_reg_write,
  output logic [NB_DATA-1:0] o_selected_data,
  output logic [NB_REG-1:0]  o_selected_reg,
  output logic               o_hlt,
  output logic               o_misaligned,
  output logic [NB_CNT-1:0]  o_retired
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               reg_write_q, reg_write_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic [NB_REG-1:0]  reg_q, reg_d;
  logic               mis_q, mis_d;
  logic [NB_CNT-1:0]  cnt_q, cnt_d;
  logic [NB_PC-1:0]   link_pc;
  logic               load_sel;

  function automatic logic [NB_DATA-1:0] format_load(input logic [NB_DATA-1:0] mem,
                                                     input logic [1:0] size,
                                                     input logic uns,
                                                     input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = mem[{off, 3'b000} +: 8];
    h = mem[{off[1], 4'b0000} +: 16];
    case (size)
      2'b00:   format_load = {{(NB_DATA-8){b[7] & ~uns}}, b};
      2'b01:   format_load = {{(NB_DATA-16){h[15] & ~uns}}, h};
      default: format_load = mem;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = off[0];
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction

  function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] c);
    sat_inc = (&c) ? c : c + NB_CNT'(1);
  endfunction

  assign link_pc  = i_pc + NB_PC'(LINK_OFFSET);
  // Link write-back wins over a load, so such a bundle is never treated as a load.
  assign load_sel = i_mem_to_reg && !i_r31_ctrl;

  always_comb begin
    state_d     = state_q;
    reg_write_d = reg_write_q;
    data_d      = data_q;
    reg_d       = reg_q;
    mis_d       = mis_q;
    cnt_d       = cnt_q;
    if (state_q == ST_RUN && !i_stall) begin
      if (!i_valid || i_flush || i_hlt) begin
        reg_write_d = 1'b0;
        data_d      = '0;
        reg_d       = '0;
        mis_d       = 1'b0;
        if (i_valid && !i_flush) state_d = ST_HALTED;
      end else begin
        mis_d = load_sel && is_misaligned(i_load_size, i_byte_off);
        if (i_r31_ctrl)        data_d = NB_DATA'(link_pc);
        else if (i_mem_to_reg) data_d = format_load(i_mem_data, i_load_size,
                                                    i_load_unsigned, i_byte_off);
        else                   data_d = i_alu_result;
        reg_d       = i_selected_reg;
        reg_write_d = i_reg_write && (i_selected_reg != '0) && !mis_d;
        cnt_d       = sat_inc(cnt_q);
      end
    end
  end

  // ---- MEM/WB boundary register ----
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_RUN;
      reg_write_q <= 1'b0;
      data_q      <= '0;
      reg_q       <= '0;
      mis_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      reg_write_q <= reg_write_d;
      data_q      <= data_d;
      reg_q       <= reg_d;
      mis_q       <= mis_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_reg_write     = reg_write_q;
  assign o_selected_data = data_q;
  assign o_selected_reg  = reg_q;
  assign o_hlt           = (state_q == ST_HALTED);
  assign o_misaligned    = mis_q;
  assign o_retired       = cnt_q;

endmodule
